// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the serial instruction-memory loader.
// Optional checksum verification is enabled by defining IMEM_LOADER_CHECKSUM_EN.
package imem_loader_pkg;

  typedef enum logic [2:0] {
    SYNC,
    CNT_LO,
    CNT_HI,
    DATA,
    CSUM,
    DONE,
    ERR
  } loader_state_t;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_t;

  localparam logic [7:0] LOADER_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver, LSB first, with a double-flopped input and glitch
// rejection on the start bit; reports each byte as valid or stop-bit error.
module uart_rx_byte
  import imem_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       byte_err
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  rx_state_t     state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [2:0]    bit_idx, bit_idx_next;
  logic [7:0]    shift, shift_next;
  logic          valid_next, err_next;
  logic          rx_meta, rx_sync, rx_prev;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  // The synchronizer resets to the idle (high) level so reset release never
  // looks like a start-bit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_prev    <= 1'b1;
      state      <= RX_IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      byte_valid <= 1'b0;
      byte_err   <= 1'b0;
    end else begin
      rx_meta    <= rx;
      rx_sync    <= rx_meta;
      rx_prev    <= rx_sync;
      state      <= state_next;
      cnt        <= cnt_next;
      bit_idx    <= bit_idx_next;
      shift      <= shift_next;
      byte_valid <= valid_next;
      byte_err   <= err_next;
    end
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave a value unassigned and infer a latch.
  always_comb begin
    state_next   = state;
    cnt_next     = cnt;
    bit_idx_next = bit_idx;
    shift_next   = shift;
    valid_next   = 1'b0;
    err_next     = 1'b0;
    unique case (state)
      RX_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_next = RX_START;
          cnt_next   = '0;
        end
      end
      RX_START: begin
        if (cnt == HALF_LAST) begin
          cnt_next     = '0;
          bit_idx_next = '0;
          state_next   = rx_sync ? RX_IDLE : RX_DATA;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          shift_next = {rx_sync, shift[7:1]};
          if (bit_idx == 3'd7) state_next = RX_STOP;
          else                 bit_idx_next = bit_idx + 3'd1;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      RX_STOP: begin
        if (cnt == BIT_LAST) begin
          cnt_next   = '0;
          state_next = RX_IDLE;
          valid_next = rx_sync;
          err_next   = !rx_sync;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      default: state_next = RX_IDLE;
    endcase
  end

  assign byte_data = shift;

endmodule

// File: rtl/imem_loader.sv
// Framed serial program loader: writes 32-bit words into instruction memory and
// releases the core after a good image. Define IMEM_LOADER_CHECKSUM_EN to verify the checksum.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          CLKS_PER_BIT = 434,
  parameter logic [31:0] BASE_ADDR    = 32'h0,
  parameter int          MAX_WORDS    = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        rx,
  output logic        im_wr_en,
  output logic [31:0] im_wr_addr,
  output logic [31:0] im_wr_data,
  output logic        core_enable,
  output logic        core_reset,
  output logic        load_done,
  output logic        load_err
);

  localparam logic [16:0] MAX_N = 17'(MAX_WORDS);

  loader_state_t state, state_next;
  logic          byte_valid, byte_err;
  logic [7:0]    byte_data;
  logic [7:0]    count_lo;
  logic [15:0]   count, word_idx, count_rx;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic          is_sync;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]    csum;
`endif

  uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_err   (byte_err)
  );

  assign is_sync  = byte_valid && (byte_data == LOADER_SYNC_BYTE);
  assign count_rx = {byte_data, count_lo};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= SYNC;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      SYNC, DONE, ERR: if (is_sync) state_next = CNT_LO;
      CNT_LO: begin
        if (byte_err)        state_next = ERR;
        else if (byte_valid) state_next = CNT_HI;
      end
      CNT_HI: begin
        if (byte_err) state_next = ERR;
        else if (byte_valid) begin
          if ({1'b0, count_rx} > MAX_N) state_next = ERR;
          else if (count_rx == 16'd0)   state_next = CSUM;
          else                          state_next = DATA;
        end
      end
      DATA: begin
        if (byte_err) state_next = ERR;
        else if (byte_valid && byte_idx == 2'd3 && word_idx + 16'd1 == count)
          state_next = CSUM;
      end
      CSUM: begin
        if (byte_err) state_next = ERR;
        else if (byte_valid) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_next = (byte_data == csum) ? DONE : ERR;
`else
          state_next = DONE;
`endif
        end
      end
      default: state_next = SYNC;
    endcase
  end

  // Bytes arrive LSB-first into the top of word_buf, so after three shifts
  // byte 0 sits in [7:0] and the fourth byte completes the word on top.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im_wr_en   <= 1'b0;
      im_wr_addr <= '0;
      im_wr_data <= '0;
      count_lo   <= '0;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
    end else begin
      im_wr_en <= 1'b0;
      if (byte_valid) begin
        unique case (state)
          SYNC, DONE, ERR: begin
            if (is_sync) begin
              count_lo <= '0;
              count    <= '0;
              word_idx <= '0;
              byte_idx <= '0;
            end
          end
          CNT_LO: count_lo <= byte_data;
          CNT_HI: count    <= count_rx;
          DATA: begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              im_wr_en   <= 1'b1;
              im_wr_addr <= BASE_ADDR + {14'b0, word_idx, 2'b00};
              im_wr_data <= {byte_data, word_buf};
              word_idx   <= word_idx + 16'd1;
            end else begin
              word_buf <= {byte_data, word_buf[23:8]};
            end
          end
          default: ;
        endcase
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) csum <= '0;
    else if (is_sync && (state == SYNC || state == DONE || state == ERR))
      csum <= '0;
    else if (byte_valid && (state == CNT_LO || state == CNT_HI || state == DATA))
      csum <= csum ^ byte_data;
  end
`endif

  assign load_done   = (state == DONE);
  assign core_reset  = (state == DONE);
  assign core_enable = (state == DONE);
  assign load_err    = (state == ERR);

endmodule
